// File: rtl/latch_write_arbiter.sv
// Round-robin write arbiter that lets N_REQ requesters share one latch bank.
// Define LATCH_ARB_LOCK_EN to let a locked winner keep the bank for back-to-back writes.
module latch_write_arbiter #(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = 8,
    parameter int HOLD_CYC = 2
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [N_REQ-1:0]       REQ,
    input  logic [N_REQ*WIDTH-1:0] DIN,
    input  logic [N_REQ-1:0]       LOCK,
    output logic [N_REQ-1:0]       GNT,
    output logic [N_REQ-1:0]       ACK,
    output logic                   EN,
    output logic [WIDTH-1:0]       D,
    output logic                   BUSY
);

    localparam int PW = $clog2(N_REQ);
    // Counter is loaded with the last index so that zero marks the final EN cycle.
    localparam logic [3:0] HOLD_LAST = (HOLD_CYC <= 1) ? 4'd0 : 4'(HOLD_CYC - 1);

    // Handshake: REQ is a level; GNT rises one cycle after a REQ is sampled in IDLE,
    // EN follows for HOLD_CYC cycles, and ACK pulses once when the write completes.
    typedef enum logic [1:0] {IDLE, GRANT, WRITE, RELEASE} state_t;

    state_t            state, next_state;
    logic [PW-1:0]     ptr, win, pick;
    logic [PW:0]       cand;
    logic              found;
    logic              relock;
    logic [3:0]        cnt;
    logic [N_REQ-1:0]  pick_onehot;
    logic [WIDTH-1:0]  pick_data, win_data;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, ptr} + (PW+1)'(i);
            if (cand >= (PW+1)'(N_REQ)) cand = cand - (PW+1)'(N_REQ);
            if (!found && REQ[cand[PW-1:0]]) begin
                found = 1'b1;
                pick  = cand[PW-1:0];
            end
        end
    end

    always_comb begin
        pick_onehot = '0;
        pick_data   = '0;
        win_data    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (PW'(i) == pick) begin
                pick_onehot[i] = 1'b1;
                pick_data      = DIN[i*WIDTH +: WIDTH];
            end
            if (PW'(i) == win) win_data = DIN[i*WIDTH +: WIDTH];
        end
    end

`ifdef LATCH_ARB_LOCK_EN
    assign relock = LOCK[win] & REQ[win];
`else
    logic unused_lock;
    assign unused_lock = ^LOCK;
    assign relock      = 1'b0;
`endif

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (found) next_state = GRANT;
            GRANT:   next_state = WRITE;
            WRITE:   if (cnt == 4'd0) next_state = RELEASE;
            RELEASE: next_state = relock ? GRANT : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            GNT   <= '0;
            ACK   <= '0;
            EN    <= 1'b0;
            D     <= '0;
            ptr   <= '0;
            win   <= '0;
            cnt   <= 4'd0;
        end else begin
            state <= next_state;
            ACK   <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        win <= pick;
                        GNT <= pick_onehot;
                        D   <= pick_data;
                    end
                end
                GRANT: begin
                    EN  <= 1'b1;
                    cnt <= HOLD_LAST;
                end
                WRITE: begin
                    if (cnt == 4'd0) begin
                        EN  <= 1'b0;
                        ACK <= GNT;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RELEASE: begin
                    // A relocked winner keeps GNT and the pointer; only the data is refreshed.
                    if (relock) begin
                        D <= win_data;
                    end else begin
                        GNT <= '0;
                        ptr <= (int'(win) == N_REQ - 1) ? '0 : win + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_latch_write_arbiter.sv
// Bench for latch_write_arbiter: a HOLD_CYC=2 and a HOLD_CYC=0 instance share stimulus,
// a transaction-timeline model is compared every cycle, and directed literals pin key points.
module tb_latch_write_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam int HOLD_A = 2;
  localparam int HOLD_B = 0;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] req, lock;
  logic [N*W-1:0] din;
  logic [N-1:0] gnt_a, ack_a, gnt_b, ack_b;
  logic en_a, en_b, busy_a, busy_b;
  logic [W-1:0] d_a, d_b;

  int checks = 0;
  int errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  latch_write_arbiter #(.N_REQ(N), .WIDTH(W), .HOLD_CYC(HOLD_A)) dut_a (
    .CLK(clk), .RST(rst), .REQ(req), .DIN(din), .LOCK(lock),
    .GNT(gnt_a), .ACK(ack_a), .EN(en_a), .D(d_a), .BUSY(busy_a)
  );

  latch_write_arbiter #(.N_REQ(N), .WIDTH(W), .HOLD_CYC(HOLD_B)) dut_b (
    .CLK(clk), .RST(rst), .REQ(req), .DIN(din), .LOCK(lock),
    .GNT(gnt_b), .ACK(ack_b), .EN(en_b), .D(d_b), .BUSY(busy_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: each active transaction is a timeline k = cycles since REQ was sampled.
  // k=1 grant, k=2..hold+1 EN high, k=hold+2 ACK; a lock restarts at k=1.
  int m_hold[2];
  bit m_act[2];
  int m_k[2], m_win[2], m_ptr[2];
  logic [W-1:0] m_d[2];
  bit armed = 1'b0;
  bit lock_en;

  initial begin
    m_hold[0] = (HOLD_A == 0) ? 1 : HOLD_A;
    m_hold[1] = (HOLD_B == 0) ? 1 : HOLD_B;
`ifdef LATCH_ARB_LOCK_EN
    lock_en = 1'b1;
`else
    lock_en = 1'b0;
`endif
  end

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (rst) begin
        armed = 1'b1;
        m_act[u] = 1'b0; m_k[u] = 0; m_ptr[u] = 0; m_d[u] = '0; m_win[u] = 0;
      end else if (!m_act[u]) begin
        if (req != '0) begin
          for (int i = 0; i < N; i++) begin
            if (!m_act[u] && req[(m_ptr[u] + i) % N]) begin
              m_win[u] = (m_ptr[u] + i) % N;
              m_act[u] = 1'b1;
            end
          end
          m_d[u] = din[m_win[u]*W +: W];
          m_k[u] = 1;
        end
      end else if (m_k[u] == m_hold[u] + 2) begin
        if (lock_en && lock[m_win[u]] && req[m_win[u]]) begin
          m_k[u] = 1;
          m_d[u] = din[m_win[u]*W +: W];
        end else begin
          m_act[u] = 1'b0;
          m_k[u] = 0;
          m_ptr[u] = (m_win[u] + 1) % N;
        end
      end else begin
        m_k[u]++;
      end
    end
  end

  task automatic cmp_unit(input int u, input string p, input logic [N-1:0] g, input logic [N-1:0] a,
                          input logic e, input logic b, input logic [W-1:0] d);
    logic [N-1:0] oh;
    oh = '0;
    if (m_act[u]) oh[m_win[u]] = 1'b1;
    chk({p, "_gnt"}, 32'(g), 32'(oh));
    chk({p, "_en"}, 32'(e), 32'(m_act[u] && m_k[u] >= 2 && m_k[u] <= m_hold[u] + 1));
    chk({p, "_ack"}, 32'(a), (m_act[u] && m_k[u] == m_hold[u] + 2) ? 32'(oh) : 32'd0);
    chk({p, "_busy"}, 32'(b), 32'(m_act[u]));
    chk({p, "_d"}, 32'(d), 32'(m_d[u]));
  endtask

  // scoreboard compare every cycle once reset has been seen
  always @(negedge clk) begin
    if (armed) begin
      cmp_unit(0, "mdl_a", gnt_a, ack_a, en_a, busy_a, d_a);
      cmp_unit(1, "mdl_b", gnt_b, ack_b, en_b, busy_b, d_b);
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; lock = '0; din = '0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic drain(input int n);
    req = '0; lock = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  int exp_rr[5] = '{0, 1, 2, 3, 0};
  int g_idx[$];
  int g_cyc[$];
  logic [N-1:0] last_g;

  initial begin
    rst = 1'b1; req = '0; lock = '0; din = '0;

    // reset state
    do_reset();
    chk("rst_gnt", 32'(gnt_a), 32'h0);
    chk("rst_en", 32'(en_a), 32'h0);
    chk("rst_d", 32'(d_a), 32'h0);
    chk("rst_busy", 32'(busy_a), 32'h0);
    chk("rst_ack", 32'(ack_a), 32'h0);

    // single requester
    do_reset();
    din[15:8] = 8'hA5; req = 4'b0010;
    step();
    chk("s1_gnt_c1", 32'(gnt_a), 32'h2);
    chk("s1_b_gnt_c1", 32'(gnt_b), 32'h2);
    req = '0;
    step();
    chk("s1_en_c2", 32'(en_a), 32'h1);
    chk("s1_d_c2", 32'(d_a), 32'hA5);
    chk("s1_b_en_c2", 32'(en_b), 32'h1);
    step();
    chk("s1_en_c3", 32'(en_a), 32'h1);
    chk("s1_b_en_c3", 32'(en_b), 32'h0);
    chk("s1_b_ack_c3", 32'(ack_b), 32'h2);
    step();
    chk("s1_ack_c4", 32'(ack_a), 32'h2);
    chk("s1_en_c4", 32'(en_a), 32'h0);
    chk("s1_b_busy_c4", 32'(busy_b), 32'h0);
    step();
    chk("s1_busy_c5", 32'(busy_a), 32'h0);
    chk("s1_gnt_c5", 32'(gnt_a), 32'h0);
    drain(3);

    // round-robin with all requests held
    do_reset();
    din = 32'h44332211; req = 4'b1111;
    last_g = '0;
    for (int c = 1; c <= 22; c++) begin
      step();
      if (last_g == '0 && gnt_a != '0) begin
        for (int i = 0; i < N; i++) if (gnt_a[i]) g_idx.push_back(i);
        g_cyc.push_back(c);
      end
      last_g = gnt_a;
    end
    chk("rr_count", 32'(g_idx.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < g_idx.size()) begin
        chk("rr_order", 32'(g_idx[i]), 32'(exp_rr[i]));
        chk("rr_cycle", 32'(g_cyc[i]), 32'(1 + 5 * i));
      end
    end
    drain(6);

    // winner drops REQ during WRITE
    do_reset();
    din[23:16] = 8'h3C; req = 4'b0100;
    step();
    chk("drop_gnt_c1", 32'(gnt_a), 32'h4);
    step();
    chk("drop_en_c2", 32'(en_a), 32'h1);
    req = '0;
    step();
    chk("drop_en_c3", 32'(en_a), 32'h1);
    chk("drop_d_c3", 32'(d_a), 32'h3C);
    step();
    chk("drop_en_c4", 32'(en_a), 32'h0);
    chk("drop_ack_c4", 32'(ack_a), 32'h4);
    step();
    chk("drop_busy_c5", 32'(busy_a), 32'h0);
    drain(3);

    // reset in the second WRITE cycle
    do_reset();
    din[15:8] = 8'h5A; req = 4'b0010;
    step(); step(); step();
    chk("mid_en_c3", 32'(en_a), 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_en_c4", 32'(en_a), 32'h0);
    chk("mid_gnt_c4", 32'(gnt_a), 32'h0);
    chk("mid_d_c4", 32'(d_a), 32'h0);
    chk("mid_ack_c4", 32'(ack_a), 32'h0);
    chk("mid_busy_c4", 32'(busy_a), 32'h0);
    req = 4'b1000; din[31:24] = 8'h99;
    step();
    chk("mid_gnt_c5", 32'(gnt_a), 32'h8);
    chk("mid_d_c5", 32'(d_a), 32'h99);
    chk("mid_ack_c5", 32'(ack_a), 32'h0);
    req = '0;
    drain(6);

    // lock hint on requester 0
    do_reset();
    din[7:0] = 8'h11; din[15:8] = 8'h22; req = 4'b0011; lock = 4'b0001;
    step();
    chk("lk_gnt_c1", 32'(gnt_a), 32'h1);
    chk("lk_d_c1", 32'(d_a), 32'h11);
    step(); step(); step();
    chk("lk_ack_c4", 32'(ack_a), 32'h1);
    din[7:0] = 8'h77;
    step();
`ifdef LATCH_ARB_LOCK_EN
    chk("lk_gnt_c5", 32'(gnt_a), 32'h1);
    chk("lk_busy_c5", 32'(busy_a), 32'h1);
    chk("lk_d_c5", 32'(d_a), 32'h77);
    lock = '0;
    step(); step(); step();
    chk("lk_ack_c8", 32'(ack_a), 32'h1);
    step();
    chk("lk_busy_c9", 32'(busy_a), 32'h0);
    step();
    chk("lk_gnt_c10", 32'(gnt_a), 32'h2);
    chk("lk_d_c10", 32'(d_a), 32'h22);
`else
    chk("lk_busy_c5", 32'(busy_a), 32'h0);
    chk("lk_gnt_c5", 32'(gnt_a), 32'h0);
    step();
    chk("lk_gnt_c6", 32'(gnt_a), 32'h2);
    chk("lk_d_c6", 32'(d_a), 32'h22);
`endif
    drain(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
